// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool window sequencer:
// state encoding, default frame geometry and the frame-dimension check.
package maxpool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  // 2x2/stride-2 pooling only tiles cleanly when both dimensions are even.
  function automatic bit dims_ok(input int w, input int h);
    return (w >= 2) && (h >= 2) && (w % 2 == 0) && (h % 2 == 0);
  endfunction

endpackage

// File: rtl/maxpool_wrap_counter.sv
// Modulo-MAX counter with synchronous clear; Wrap flags the terminal count
// so a cascaded counter can be enabled on the same cycle.
module maxpool_wrap_counter
  import maxpool_pkg::*;
#(
  parameter int MAX   = IMG_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Clr,
  output logic [CNT_W-1:0] Count,
  output logic             Wrap
);

  assign Wrap = (Count == CNT_W'(MAX - 1));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (En) begin
      Count <= Wrap ? '0 : Count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/maxpool_window_controller.sv
// Frame sequencer for the 2x2 max-pool datapath: Start/Busy/Done handshake,
// raster position tracking and per-pixel datapath strobes.
module maxpool_window_controller
  import maxpool_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             In_Valid,
  output logic             Busy,
  output logic             Done,
  output logic             Pair_Load,
  output logic             Pair_Max,
  output logic             Lb_Wr_En,
  output logic             Lb_Rd_En,
  output logic [CNT_W-2:0] Lb_Addr,
  output logic             Out_Valid,
  output logic [CNT_W-2:0] Out_Col,
  output logic [CNT_W-2:0] Out_Row
);

  generate
    if (!dims_ok(IMG_W, IMG_H)) begin : g_dim_err
      $error("maxpool_window_controller: IMG_W/IMG_H must be even and >= 2");
    end
    if ((2 ** CNT_W) <= IMG_W || (2 ** CNT_W) <= IMG_H) begin : g_cnt_err
      $error("maxpool_window_controller: CNT_W too narrow for frame size");
    end
  endgenerate

  state_t           state, state_nxt;
  logic             acc, start_go, last_pix;
  logic             col_wrap, row_wrap;
  logic [CNT_W-1:0] col, row;

  assign acc      = In_Valid & (state == RUN);
  assign start_go = Start & (state == IDLE);
  assign last_pix = acc & col_wrap & row_wrap;

  maxpool_wrap_counter #(.MAX(IMG_W), .CNT_W(CNT_W)) u_col (
    .Clk   (Clk),
    .Rst   (Rst),
    .En    (acc),
    .Clr   (start_go),
    .Count (col),
    .Wrap  (col_wrap)
  );

  maxpool_wrap_counter #(.MAX(IMG_H), .CNT_W(CNT_W)) u_row (
    .Clk   (Clk),
    .Rst   (Rst),
    .En    (acc & col_wrap),
    .Clr   (start_go),
    .Count (row),
    .Wrap  (row_wrap)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (last_pix) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

  // Even column opens a horizontal pair, odd column closes it; the row parity
  // picks whether the pair max goes into the line buffer or meets its partner.
  assign Pair_Load = acc & ~col[0];
  assign Pair_Max  = acc & col[0];
  assign Lb_Wr_En  = acc & col[0] & ~row[0];
  assign Lb_Rd_En  = acc & col[0] & row[0];
  assign Lb_Addr   = (Lb_Wr_En | Lb_Rd_En) ? col[CNT_W-1:1] : '0;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Out_Valid <= 1'b0;
      Out_Col   <= '0;
      Out_Row   <= '0;
    end else begin
      Out_Valid <= Lb_Rd_En;
      if (Lb_Rd_En) begin
        Out_Col <= col[CNT_W-1:1];
        Out_Row <= row[CNT_W-1:1];
      end
    end
  end

endmodule

// File: tb/tb_maxpool_window_controller.sv
// Scoreboard bench: a 4x4 instance for directed handshake/strobe cases and a
// 28x28 instance for a full-size frame.
module tb_maxpool_window_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- 4x4 instance ----------------
  logic        rst4 = 1'b0, start4 = 1'b0, in4 = 1'b0;
  logic        busy4, done4, pl4, pm4, wr4, rd4, ov4;
  logic [14:0] addr4, ocol4, orow4;

  maxpool_window_controller #(.IMG_W(4), .IMG_H(4), .CNT_W(16)) dut4 (
    .Clk(clk), .Rst(rst4), .Start(start4), .In_Valid(in4),
    .Busy(busy4), .Done(done4), .Pair_Load(pl4), .Pair_Max(pm4),
    .Lb_Wr_En(wr4), .Lb_Rd_En(rd4), .Lb_Addr(addr4),
    .Out_Valid(ov4), .Out_Col(ocol4), .Out_Row(orow4)
  );

  // ---------------- 28x28 instance ----------------
  logic        rst28 = 1'b0, start28 = 1'b0, in28 = 1'b0;
  logic        busy28, done28, pl28, pm28, wr28, rd28, ov28;
  logic [14:0] addr28, ocol28, orow28;

  maxpool_window_controller #(.IMG_W(28), .IMG_H(28), .CNT_W(16)) dut28 (
    .Clk(clk), .Rst(rst28), .Start(start28), .In_Valid(in28),
    .Busy(busy28), .Done(done28), .Pair_Load(pl28), .Pair_Max(pm28),
    .Lb_Wr_En(wr28), .Lb_Rd_En(rd28), .Lb_Addr(addr28),
    .Out_Valid(ov28), .Out_Col(ocol28), .Out_Row(orow28)
  );

  // Expected strobes packed as addr*16 + {load,max,wr,rd}; outputs as col*256+row.
  int exp_strb4[$];
  int exp_out4[$];
  int exp_out28[$];
  int win4_tbl[4] = '{0 * 256 + 0, 1 * 256 + 0, 0 * 256 + 1, 1 * 256 + 1};

  int acc28_cnt = 0, out28_cnt = 0, max_addr28 = 0;
  int last_col28 = -1, last_row28 = -1;

  always @(negedge clk) begin
    int act;
    if (pl4 || pm4 || wr4 || rd4 || addr4 != 0) begin
      act = int'(addr4) * 16 + int'({pl4, pm4, wr4, rd4});
      if (exp_strb4.size() == 0) chk("strobe4_unexpected", act, 0);
      else chk("strobe4", act, exp_strb4.pop_front());
    end
    if (ov4) begin
      act = int'(ocol4) * 256 + int'(orow4);
      if (exp_out4.size() == 0) chk("out4_unexpected", act, -1);
      else chk("out4_coord", act, exp_out4.pop_front());
    end
  end

  always @(negedge clk) begin
    int act;
    if (pl28 || pm28) acc28_cnt++;
    if ((wr28 || rd28) && int'(addr28) > max_addr28) max_addr28 = int'(addr28);
    if (ov28) begin
      out28_cnt++;
      last_col28 = int'(ocol28);
      last_row28 = int'(orow28);
      act = last_col28 * 256 + last_row28;
      if (exp_out28.size() == 0) chk("out28_unexpected", act, -1);
      else chk("out28_coord", act, exp_out28.pop_front());
    end
  end

  task automatic frame4(input int npix, input bit gap, input bit poke_run);
    int w;
    w = 0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("busy4_after_start", busy4, 1);
    for (int p = 0; p < npix; p++) begin
      int r, c, ld, mx, wr, rd, ad;
      r  = p / 4;
      c  = p % 4;
      ld = (c % 2 == 0);
      mx = (c % 2 == 1);
      wr = mx && (r % 2 == 0);
      rd = mx && (r % 2 == 1);
      ad = (wr || rd) ? c / 2 : 0;
      exp_strb4.push_back(ad * 16 + ld * 8 + mx * 4 + wr * 2 + rd);
      if (rd) begin
        exp_out4.push_back(win4_tbl[w]);
        w++;
      end
      in4 = 1'b1;
      if (poke_run && p == 6) start4 = 1'b1;
      tick();
      in4 = 1'b0;
      start4 = 1'b0;
      if (gap && p != npix - 1) tick();
    end
  endtask

  task automatic finish4(input bit poke_done);
    chk("done4_after_last", done4, 1);
    chk("busy4_after_last", busy4, 0);
    if (poke_done) start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("done4_pulse_end", done4, 0);
    chk("busy4_idle", busy4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_strobes", int'({pl4, pm4, wr4, rd4}), 0);
    chk("rst_out_valid", ov4, 0);
    chk("rst_out_coord", int'(ocol4) + int'(orow4) + int'(addr4), 0);
    chk("rst_busy28", busy28, 0);
    rst4 = 1'b1;
    rst28 = 1'b1;
    tick();

    // Abandon a frame after 7 pixels.
    frame4(7, 1'b0, 1'b0);
    chk("mid_busy_before_rst", busy4, 1);
    rst4 = 1'b0;
    #1;
    chk("mid_rst_busy", busy4, 0);
    chk("mid_rst_done", done4, 0);
    chk("mid_rst_out_valid", ov4, 0);
    chk("mid_rst_coord", int'(ocol4) + int'(orow4) + int'(addr4), 0);
    chk("mid_rst_strb_drained", exp_strb4.size(), 0);
    chk("mid_rst_out_drained", exp_out4.size(), 0);
    tick();
    rst4 = 1'b1;
    tick();

    // Restart after reset, continuous stream.
    frame4(16, 1'b0, 1'b0);
    finish4(1'b0);
    // Gapped stream with Start poked mid-frame and during DONE.
    frame4(16, 1'b1, 1'b1);
    finish4(1'b1);
    // Start two cycles after the last pixel.
    frame4(16, 1'b0, 1'b0);
    finish4(1'b0);

    // In_Valid while idle must not move anything.
    in4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i % 3 == 0) chk("idle_busy", busy4, 0);
    end
    in4 = 1'b0;
    tick();
    chk("strb4_queue_empty", exp_strb4.size(), 0);
    chk("out4_queue_empty", exp_out4.size(), 0);

    // Full 28x28 frame.
    start28 = 1'b1;
    tick();
    start28 = 1'b0;
    chk("busy28_after_start", busy28, 1);
    for (int p = 0; p < 784; p++) begin
      int r, c;
      r = p / 28;
      c = p % 28;
      if ((r % 2 == 1) && (c % 2 == 1)) exp_out28.push_back((c / 2) * 256 + (r / 2));
      in28 = 1'b1;
      tick();
    end
    in28 = 1'b0;
    chk("done28_after_last", done28, 1);
    chk("busy28_after_last", busy28, 0);
    tick();
    chk("done28_pulse_end", done28, 0);
    repeat (2) tick();
    chk("acc28_count", acc28_cnt, 784);
    chk("out28_count", out28_cnt, 196);
    chk("out28_last_col", last_col28, 13);
    chk("out28_last_row", last_row28, 13);
    chk("lb_addr28_max", max_addr28, 13);
    chk("out28_queue_empty", exp_out28.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
